// File: rtl/rr_arb_pkg.sv
// Shared types, constants and the rotating-priority search for rr_arbiter_8.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  // First set bit of req at or above ptr, wrapping 7->0; 0 when req is empty.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] cand;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/decoder_3_to_8.sv
// 3-to-8 one-hot decoder with enable; all outputs low when disabled.
module decoder_3_to_8 (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [7:0] dec
);

  // One-hot decode of idx, gated by en.
  always_comb begin
    dec = '0;
    if (en) dec[idx] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter. A grant is held until the owner pulses done or
// drops its request; every grant is followed by at least one IDLE cycle.
// Optional macro RR_ARB_TIMEOUT_EN: revoke a grant after MAX_HOLD cycles and
// pulse out_timeout; without it out_timeout is tied low.
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       in_clk,
  input  logic       in_rst_n,
  input  logic [7:0] in_req,
  input  logic       in_done,
  output logic [7:0] out_gnt,
  output logic [2:0] out_gnt_idx,
  output logic       out_gnt_valid,
  output logic       out_timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
  end

  arb_state_t       state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [IDX_W-1:0] idx_nxt;
  logic             timeout_nxt;
  logic             rel_normal;
  logic             rel_force;

  assign rel_normal = in_done || !in_req[out_gnt_idx];

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt;

  // Hold counter: held at zero while idle, so it reads 0 on the first GRANT cycle.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n)          hold_cnt <= '0;
    else if (state == IDLE) hold_cnt <= '0;
    else                    hold_cnt <= hold_cnt + 8'd1;
  end

  assign rel_force = (hold_cnt == HOLD_LAST);
`else
  assign rel_force = 1'b0;
`endif

  // Next-state, pointer, index and timeout-pulse logic.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    idx_nxt     = out_gnt_idx;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (|in_req) begin
          idx_nxt   = rr_pick(in_req, ptr);
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        if (rel_normal || rel_force) begin
          state_nxt   = IDLE;
          ptr_nxt     = out_gnt_idx + IDX_W'(1);
          timeout_nxt = rel_force && !rel_normal;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, pointer, index and timeout registers.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      out_gnt_idx <= '0;
      out_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      out_gnt_idx <= idx_nxt;
      out_timeout <= timeout_nxt;
    end
  end

  assign out_gnt_valid = (state == GRANT);

  decoder_3_to_8 u_dec (
    .idx (out_gnt_idx),
    .en  (out_gnt_valid),
    .dec (out_gnt)
  );

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Scoreboard bench for rr_arbiter_8: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_rr_arbiter_8;

`ifdef RR_ARB_TIMEOUT_EN
  localparam int MH = 4;
`else
  localparam int MH = 16;
`endif

  logic       in_clk;
  logic       in_rst_n;
  logic [7:0] in_req;
  logic       in_done;
  logic [7:0] out_gnt;
  logic [2:0] out_gnt_idx;
  logic       out_gnt_valid;
  logic       out_timeout;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_req        (in_req),
    .in_done       (in_done),
    .out_gnt       (out_gnt),
    .out_gnt_idx   (out_gnt_idx),
    .out_gnt_valid (out_gnt_valid),
    .out_timeout   (out_timeout)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       valid;
    logic       to;
  } exp_t;

  exp_t sb[$];
  int   order[$];
  int   n_vec = 0;
  int   n_err = 0;
  logic prev_valid;

  // Reference model state
  bit m_busy;
  int m_ptr, m_idx, m_cnt;
  bit m_to;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_idx = 0; m_cnt = 0; m_to = 0;
    sb.delete();
    prev_valid = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] r, input logic d);
    bit   rel, forced, found;
    exp_t e;
    if (!m_busy) begin
      m_to  = 0;
      found = 0;
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (!found && r[j]) begin
          found  = 1;
          m_idx  = j;
          m_busy = 1;
          m_cnt  = 0;
        end
      end
    end else begin
      rel    = d || !r[m_idx];
      forced = 0;
`ifdef RR_ARB_TIMEOUT_EN
      forced = !rel && (m_cnt == MH - 1);
`endif
      if (rel || forced) begin
        m_busy = 0;
        m_ptr  = (m_idx + 1) % 8;
        m_to   = forced;
      end else begin
        m_cnt++;
        m_to = 0;
      end
    end
    e.gnt   = m_busy ? 8'(1 << m_idx) : 8'h00;
    e.idx   = 3'(m_idx);
    e.valid = m_busy;
    e.to    = m_to;
    sb.push_back(e);
  endtask

  task automatic cycle(input logic [7:0] r, input logic d);
    exp_t e;
    in_req  = r;
    in_done = d;
    model_step(r, d);
    @(posedge in_clk);
    #1;
    if (sb.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_val("gnt",     32'(out_gnt),       32'(e.gnt));
      check_val("idx",     32'(out_gnt_idx),   32'(e.idx));
      check_val("valid",   32'(out_gnt_valid), 32'(e.valid));
      check_val("timeout", 32'(out_timeout),   32'(e.to));
    end
    if (out_gnt_valid && !prev_valid) order.push_back(int'(out_gnt_idx));
    prev_valid = out_gnt_valid;
  endtask

  task automatic do_reset();
    in_rst_n = 1'b0;
    in_req   = 8'hFF;
    in_done  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge in_clk);
      #1;
      check_val("rst_gnt",   32'(out_gnt),       32'h00);
      check_val("rst_valid", 32'(out_gnt_valid), 32'd0);
      check_val("rst_idx",   32'(out_gnt_idx),   32'd0);
      check_val("rst_to",    32'(out_timeout),   32'd0);
    end
    in_rst_n = 1'b1;
    in_req   = 8'h00;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_rst_n   = 1'b0;
    in_req     = 8'h00;
    in_done    = 1'b0;
    prev_valid = 1'b0;
    #2;
    do_reset();

    // Single requester 3, done three cycles into the grant
    cycle(8'h08, 1'b0);
    check_val("single_gnt", 32'(out_gnt), 32'h08);
    check_val("single_idx", 32'(out_gnt_idx), 32'd3);
    cycle(8'h08, 1'b0);
    cycle(8'h08, 1'b0);
    cycle(8'h08, 1'b1);
    check_val("single_drop", 32'(out_gnt_valid), 32'd0);
    cycle(8'h00, 1'b0);
    cycle(8'hFF, 1'b0);
    check_val("single_next_ptr4", 32'(out_gnt_idx), 32'd4);
    cycle(8'hFF, 1'b1);
    cycle(8'h00, 1'b0);

    // All requesting from ptr=0: expect order 0..7,0
    do_reset();
    order.delete();
    for (int g = 0; g < 9; g++) begin
      cycle(8'hFF, 1'b0);
      cycle(8'hFF, 1'b0);
      cycle(8'hFF, 1'b1);
    end
    check_val("order_len", 32'(order.size()), 32'd9);
    for (int i = 0; i < order.size(); i++)
      check_val("order", 32'(order[i]), 32'(i % 8));
    cycle(8'h00, 1'b0);

    // Wrap: grant 6, then 8'h81 gives 7 then 0
    cycle(8'h40, 1'b0);
    check_val("wrap_pre", 32'(out_gnt_idx), 32'd6);
    cycle(8'h40, 1'b1);
    cycle(8'h81, 1'b0);
    check_val("wrap_7", 32'(out_gnt_idx), 32'd7);
    cycle(8'h81, 1'b1);
    cycle(8'h81, 1'b0);
    check_val("wrap_0", 32'(out_gnt_idx), 32'd0);
    cycle(8'h81, 1'b1);
    cycle(8'h00, 1'b0);

    // Request drop without done
    cycle(8'h20, 1'b0);
    cycle(8'h20, 1'b0);
    cycle(8'h00, 1'b0);
    check_val("drop_valid", 32'(out_gnt_valid), 32'd0);
    check_val("drop_to", 32'(out_timeout), 32'd0);
    cycle(8'hFF, 1'b0);
    check_val("drop_ptr6", 32'(out_gnt_idx), 32'd6);
    cycle(8'hFF, 1'b1);
    cycle(8'h00, 1'b0);

    // Done with request still set: owner loses priority
    cycle(8'h11, 1'b0);
    check_val("same_first", 32'(out_gnt_idx), 32'd0);
    cycle(8'h11, 1'b1);
    cycle(8'h11, 1'b0);
    check_val("same_next", 32'(out_gnt_idx), 32'd4);
    cycle(8'h11, 1'b1);
    cycle(8'h00, 1'b0);

    // Held request, no done (timeout when compiled in)
    for (int i = 0; i < MH + 6; i++) cycle(8'h06, 1'b0);
`ifndef RR_ARB_TIMEOUT_EN
    check_val("hold_forever", 32'(out_gnt), 32'h02);
`endif
    cycle(8'h00, 1'b0);
    cycle(8'h00, 1'b0);

    // Reset asserted mid-grant drops outputs immediately
    cycle(8'hFF, 1'b0);
    check_val("midrst_pre", 32'(out_gnt_valid), 32'd1);
    #2;
    in_rst_n = 1'b0;
    #1;
    check_val("midrst_gnt",   32'(out_gnt),       32'h00);
    check_val("midrst_valid", 32'(out_gnt_valid), 32'd0);
    check_val("midrst_idx",   32'(out_gnt_idx),   32'd0);
    @(posedge in_clk);
    #1;
    in_rst_n = 1'b1;
    in_req   = 8'h00;
    model_reset();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [7:0] r;
      logic       d;
      r = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      d = ($urandom_range(0, 3) == 0);
      cycle(r, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
